multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS core. It sequences the shared ALU, the register file, the unified memory port and the PC across fetch, decode, execute, memory and writeback steps. It drives the 2-bit `ALUOp` consumed by the ALU control decoder, so one ALU serves PC increment, branch-target, address and R-type arithmetic. Memory accesses wait on a ready handshake.

---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/mem_wait_ctr.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS main controller.
// Holds the FSM state enum, opcode/funct codes and datapath select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_RWB,
    S_EXECI,
    S_IWB,
    S_BRANCH,
    S_JUMP,
    S_JR
  } ctrl_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
  localparam logic [1:0] ALUOP_SUB   = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

endpackage

// File: rtl/mem_wait_ctr.sv
// Saturating memory-wait counter with a sticky timeout flag.
// Counts stalled cycles; any non-stalled cycle clears the count.
module mem_wait_ctr
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  output logic timeout_o
);

  localparam logic [3:0] MaxCnt = 4'(MEM_WAIT_MAX);

  logic [3:0] cnt_q, cnt_d;
  logic       to_q, to_d;

  always_comb begin
    cnt_d = '0;
    to_d  = to_q;
    if (wait_i) begin
      cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 4'd1;
      if (cnt_d == MaxCnt) to_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core.
// Sequences ALU, register file, memory port and PC per instruction.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       retire,
  output logic       illegal_op,
  output logic       mem_timeout
);

  ctrl_state_t state_q, state_d;

  logic pcw_c, pcwc_c, mwr_c, irw_c;
  logic rw_c, ret_c, ill_c;
  logic mem_wait;

  // zero gates PCWriteCond inside the datapath, not here
  logic unused_zero;
  assign unused_zero = zero;

  assign mem_wait = !mem_ready &&
    (state_q == S_FETCH || state_q == S_MEMRD ||
     state_q == S_MEMWR);

  mem_wait_ctr #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .wait_i   (mem_wait),
    .timeout_o(mem_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ALUOp    = ALUOP_FUNCT;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    PCSource = PCSRC_ALU;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    pcw_c    = 1'b0;
    pcwc_c   = 1'b0;
    mwr_c    = 1'b0;
    irw_c    = 1'b0;
    rw_c     = 1'b0;
    ret_c    = 1'b0;
    ill_c    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUOp   = ALUOP_ADD;
        ALUSrcB = SRCB_FOUR;
        MemRead = 1'b1;
        if (mem_ready) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUOp   = ALUOP_ADD;
        ALUSrcB = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:
            state_d = (funct == FUNCT_JR) ?
                      S_JR : S_EXEC;
          OP_ADDI: state_d = S_EXECI;
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          default: begin
            ill_c   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUOp   = ALUOP_ADD;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        rw_c     = 1'b1;
        ret_c    = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        IorD  = 1'b1;
        mwr_c = 1'b1;
        if (mem_ready) begin
          ret_c   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegDst  = 1'b1;
        rw_c    = 1'b1;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECI: begin
        ALUOp   = ALUOP_ADD;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_IWB;
      end
      S_IWB: begin
        rw_c    = 1'b1;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUOp    = ALUOP_SUB;
        ALUSrcA  = 1'b1;
        PCSource = PCSRC_ALUOUT;
        pcwc_c   = 1'b1;
        ret_c    = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        pcw_c    = 1'b1;
        ret_c    = 1'b1;
        state_d  = S_FETCH;
      end
      S_JR: begin
        PCSource = PCSRC_REGA;
        pcw_c    = 1'b1;
        ret_c    = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign PCWrite     = pcw_c  & ~rst;
  assign PCWriteCond = pcwc_c & ~rst;
  assign MemWrite    = mwr_c  & ~rst;
  assign IRWrite     = irw_c  & ~rst;
  assign RegWrite    = rw_c   & ~rst;
  assign retire      = ret_c  & ~rst;
  assign illegal_op  = ill_c  & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl.
// Reference model: per-instruction step lists and a per-step output table.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic       ALUSrcA, PCWrite, PCWriteCond, IorD;
  logic       MemRead, MemWrite, IRWrite, RegDst;
  logic       MemtoReg, RegWrite, retire;
  logic       illegal_op, mem_timeout;

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .retire(retire),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  localparam int P_F = 0, P_D = 1, P_A = 2, P_R = 3;
  localparam int P_MW = 4, P_S = 5, P_E = 6, P_RW = 7;
  localparam int P_EI = 8, P_IW = 9, P_B = 10, P_J = 11;
  localparam int P_JR = 12, P_DI = 13;

  string pname [14] = '{"fetch", "decode", "memadr",
    "memrd", "memwb", "memwr", "exec", "rwb", "execi",
    "iwb", "branch", "jump", "jr", "decode_ill"};

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc, nret, waitrun;
  logic exp_to;

  logic [16:0] dut_vec;
  logic [6:0]  dut_en;
  assign dut_vec = {ALUOp, ALUSrcA, ALUSrcB, PCSource,
    PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
    IRWrite, RegDst, MemtoReg, RegWrite, retire,
    illegal_op};
  assign dut_en = {PCWrite, PCWriteCond, MemWrite,
    IRWrite, RegWrite, retire, illegal_op};

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] exp_vec(int ph, bit rdy);
    logic [1:0] aop, sb, ps;
    logic sa, pw, pwc, iod, mr, mw, iw;
    logic rd, m2r, rw, ret, ill;
    {aop, sb, ps} = '0;
    {sa, pw, pwc, iod, mr, mw, iw} = '0;
    {rd, m2r, rw, ret, ill} = '0;
    case (ph)
      P_F:  begin aop = 2'b10; sb = 2'b01; mr = 1;
                  pw = rdy; iw = rdy; end
      P_D:  begin aop = 2'b10; sb = 2'b11; end
      P_DI: begin aop = 2'b10; sb = 2'b11; ill = 1; end
      P_A:  begin aop = 2'b10; sa = 1; sb = 2'b10; end
      P_R:  begin iod = 1; mr = 1; end
      P_MW: begin m2r = 1; rw = 1; ret = 1; end
      P_S:  begin iod = 1; mw = 1; ret = rdy; end
      P_E:  begin sa = 1; end
      P_RW: begin rd = 1; rw = 1; ret = 1; end
      P_EI: begin aop = 2'b10; sa = 1; sb = 2'b10; end
      P_IW: begin rw = 1; ret = 1; end
      P_B:  begin aop = 2'b11; sa = 1; ps = 2'b01;
                  pwc = 1; ret = 1; end
      P_J:  begin ps = 2'b10; pw = 1; ret = 1; end
      P_JR: begin ps = 2'b11; pw = 1; ret = 1; end
      default: ;
    endcase
    return {aop, sa, sb, ps, pw, pwc, iod, mr, mw, iw,
            rd, m2r, rw, ret, ill};
  endfunction

  function automatic bit is_mem(int ph);
    return ph == P_F || ph == P_R || ph == P_S;
  endfunction

  task automatic step(input int ph, input bit rdy);
    mem_ready = rdy;
    zero = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq(pname[ph], 32'(dut_vec), 32'(exp_vec(ph, rdy)));
    check_eq("mem_timeout", 32'(mem_timeout), 32'(exp_to));
    ncyc++;
    if (retire) nret++;
    if (is_mem(ph)) begin
      if (rdy) waitrun = 0;
      else if (waitrun < 15) waitrun++;
      if (waitrun == 15) exp_to = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic rst_cycles(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      check_eq("rst_enables", 32'(dut_en), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    waitrun = 0;
    exp_to = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] o,
                           input logic [5:0] f,
                           input int wf, input int wm);
    int seq[$];
    int base, w;
    bit legal = 1;
    case (o)
      6'b100011: seq = '{P_F, P_D, P_A, P_R, P_MW};
      6'b101011: seq = '{P_F, P_D, P_A, P_S};
      6'b000000: seq = (f == 6'b001000) ?
                 '{P_F, P_D, P_JR} : '{P_F, P_D, P_E, P_RW};
      6'b001000: seq = '{P_F, P_D, P_EI, P_IW};
      6'b000100: seq = '{P_F, P_D, P_B};
      6'b000010: seq = '{P_F, P_D, P_J};
      default: begin seq = '{P_F, P_DI}; legal = 0; end
    endcase
    case (o)
      6'b100011: base = 5 + wm;
      6'b101011: base = 4 + wm;
      6'b000000: base = (f == 6'b001000) ? 3 : 4;
      6'b001000: base = 4;
      6'b000100, 6'b000010: base = 3;
      default: base = 2;
    endcase
    base += wf;
    op = o;
    funct = f;
    ncyc = 0;
    nret = 0;
    foreach (seq[i]) begin
      if (is_mem(seq[i])) begin
        w = (seq[i] == P_F) ? wf : wm;
        for (int k = 0; k < w; k++) step(seq[i], 1'b0);
        step(seq[i], 1'b1);
      end else begin
        step(seq[i], 1'($urandom_range(0, 1)));
      end
    end
    check_eq("cycles", 32'(ncyc), 32'(base));
    check_eq("retires", 32'(nret), 32'(legal));
  endtask

  logic [5:0] ops [8] = '{6'b000000, 6'b100011,
    6'b101011, 6'b000100, 6'b000010, 6'b001000,
    6'b000000, 6'b111111};

  initial begin
    rst = 1'b1;
    op = '0;
    funct = '0;
    zero = 1'b0;
    mem_ready = 1'b1;
    waitrun = 0;
    exp_to = 1'b0;
    rst_cycles(2);

    run_instr(6'b000000, 6'b100000, 0, 0);
    run_instr(6'b100011, 6'b000000, 0, 2);
    run_instr(6'b000100, 6'b000000, 0, 0);
    run_instr(6'b000100, 6'b000000, 1, 0);
    run_instr(6'b000010, 6'b000000, 0, 0);
    run_instr(6'b000000, 6'b001000, 0, 0);
    run_instr(6'b101011, 6'b000000, 1, 3);
    run_instr(6'b001000, 6'b000000, 0, 0);
    run_instr(6'b111111, 6'b000000, 0, 0);

    op = 6'b100011;
    funct = '0;
    step(P_F, 1'b1);
    step(P_D, 1'b1);
    step(P_A, 1'b1);
    rst_cycles(3);

    for (int n = 0; n < 40; n++) begin
      int s = $urandom_range(0, 7);
      logic [5:0] f = 6'($urandom);
      if (s == 6) f = 6'b001000;
      else if (f == 6'b001000) f = 6'b100000;
      run_instr(ops[s], f, $urandom_range(0, 3),
                $urandom_range(0, 3));
    end

    run_instr(6'b001000, 6'b000000, 20, 0);
    check_eq("timeout_set", 32'(mem_timeout), 32'd1);
    run_instr(6'b000100, 6'b000000, 0, 0);
    run_instr(6'b100011, 6'b000000, 0, 17);
    rst_cycles(1);
    run_instr(6'b000010, 6'b000000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule
